// File: rtl/match_window_gen.sv
// match_window_gen: pairs each right-phase beat with its left search window for the disparity cost engine
module match_window_gen #(
    parameter int MAX_DIS    = 128,
    parameter int BEAT_SIZE  = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                                        aclk,
    input  logic                                        aresetn,
    output logic                                        lp_buf_rd_en,
    input  logic [MAX_DIS*DATA_WIDTH-1:0]               lp_buf_dout,
    input  logic                                        lp_buf_empty,
    output logic                                        rp_buf_rd_en,
    input  logic [BEAT_SIZE*DATA_WIDTH:0]               rp_buf_dout,
    input  logic                                        rp_buf_empty,
    output logic [(MAX_DIS+2*BEAT_SIZE)*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                                        m_axis_tvalid,
    input  logic                                        m_axis_tready,
    output logic                                        m_axis_tlast,
    output logic                                        m_axis_tuser,
    output logic                                        err_len,
    output logic [15:0]                                 row_cnt
);
    localparam int LP_BEAT_NUM = MAX_DIS / BEAT_SIZE;
    localparam int JW = (LP_BEAT_NUM > 1) ? $clog2(LP_BEAT_NUM) : 1;
    localparam int LW = MAX_DIS * DATA_WIDTH;
    localparam int BW = BEAT_SIZE * DATA_WIDTH;
    localparam int WW = (MAX_DIS + BEAT_SIZE) * DATA_WIDTH;
    localparam logic [JW-1:0] J_LAST = JW'(LP_BEAT_NUM - 1);

    typedef enum logic [1:0] {LOAD0, LOAD1, RUN} state_t;

    state_t        state_q;
    logic [JW-1:0] j_q;
    logic [LW-1:0] cur_q;
    logic [LW-1:0] nxt_q;
    logic          first_q;
    logic [2*LW-1:0] pair;
    logic [WW-1:0] win;
    logic          beat_last;
    logic          at_wrap;
    logic          fire;

    // A beat fires only with a right beat, a free output slot and, when it crosses into the next
    // left word, that word already waiting; both pops are gated off while reset is held
    always_comb begin
        beat_last    = rp_buf_dout[BW];
        at_wrap      = (j_q == J_LAST) && !beat_last;
        fire         = aresetn && (state_q == RUN) && !rp_buf_empty &&
                       (!m_axis_tvalid || m_axis_tready) && (!at_wrap || !lp_buf_empty);
        rp_buf_rd_en = fire;
        lp_buf_rd_en = aresetn && !lp_buf_empty && ((state_q != RUN) || (fire && at_wrap));
        pair         = {nxt_q, cur_q};
        win          = pair[int'(j_q)*BW +: WW];
    end

    // Row FSM: load two left words, then slide the window one beat per fire, refilling at word ends
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q       <= LOAD0;
            j_q           <= '0;
            cur_q         <= '0;
            nxt_q         <= '0;
            first_q       <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            err_len       <= 1'b0;
            row_cnt       <= '0;
        end else begin
            if (m_axis_tready)
                m_axis_tvalid <= 1'b0;
            case (state_q)
                LOAD0: if (!lp_buf_empty) begin
                    cur_q   <= lp_buf_dout;
                    state_q <= LOAD1;
                end
                LOAD1: if (!lp_buf_empty) begin
                    nxt_q   <= lp_buf_dout;
                    first_q <= 1'b1;
                    state_q <= RUN;
                end
                default: if (fire) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= {win, rp_buf_dout[BW-1:0]};
                    m_axis_tlast  <= beat_last;
                    m_axis_tuser  <= first_q;
                    first_q       <= 1'b0;
                    if (beat_last) begin
                        j_q     <= '0;
                        row_cnt <= row_cnt + 16'd1;
                        state_q <= LOAD0;
                        if (j_q != J_LAST)
                            err_len <= 1'b1;
                    end else if (at_wrap) begin
                        j_q   <= '0;
                        cur_q <= nxt_q;
                        nxt_q <= lp_buf_dout;
                    end else begin
                        j_q <= j_q + JW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_match_window_gen.sv
// tb_match_window_gen: random rows through modelled FIFOs, outputs checked against row-stream windows
module tb_match_window_gen;
    localparam int MD = 128;
    localparam int BS = 8;
    localparam int DW = 16;
    localparam int LW = MD * DW;
    localparam int BW = BS * DW;
    localparam int OW = (MD + 2 * BS) * DW;
    localparam int NB = MD / BS;

    typedef struct packed {
        logic [OW-1:0] data;
        logic          last;
        logic          user;
    } exp_t;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          lp_buf_rd_en;
    logic [LW-1:0] lp_buf_dout = '0;
    logic          lp_buf_empty = 1'b1;
    logic          rp_buf_rd_en;
    logic [BW:0]   rp_buf_dout = '0;
    logic          rp_buf_empty = 1'b1;
    logic [OW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic          err_len;
    logic [15:0]   row_cnt;

    logic [LW-1:0] lp_q[$];
    logic [BW:0]   rp_q[$];
    exp_t          exp_q[$];
    int            fire_cyc[$];
    logic [LW-1:0] pend_word;
    int            n_cmp = 0;
    int            n_err = 0;
    int            cycn = 0;
    int            acc_cnt = 0;
    int            lp_pops = 0;
    int            saved;
    bit            rand_rdy = 1'b0;
    bit            hold_v = 1'b0;
    logic [OW-1:0] hold_d;
    logic          hold_l;
    logic          hold_u;

    always #5 aclk = ~aclk;

    match_window_gen #(.MAX_DIS(MD), .BEAT_SIZE(BS), .DATA_WIDTH(DW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .lp_buf_rd_en(lp_buf_rd_en), .lp_buf_dout(lp_buf_dout), .lp_buf_empty(lp_buf_empty),
        .rp_buf_rd_en(rp_buf_rd_en), .rp_buf_dout(rp_buf_dout), .rp_buf_empty(rp_buf_empty),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .err_len(err_len), .row_cnt(row_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int first_diff(input logic [OW-1:0] a, input logic [OW-1:0] b);
        for (int i = 0; i < OW / DW; i++)
            if (a[i*DW +: DW] !== b[i*DW +: DW]) return i;
        return 0;
    endfunction

    task automatic chk_data(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] expv);
        int d;
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            d = first_diff(obs, expv);
            $error("FAIL %s: sample %0d got %h expected %h", tag, d, obs[d*DW +: DW], expv[d*DW +: DW]);
        end
    endtask

    task automatic drive();
        lp_buf_empty = (lp_q.size() == 0);
        if (lp_q.size() > 0) lp_buf_dout = lp_q[0]; else lp_buf_dout = '0;
        rp_buf_empty = (rp_q.size() == 0);
        if (rp_q.size() > 0) rp_buf_dout = rp_q[0]; else rp_buf_dout = '0;
        if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
    endtask

    // One clock: sample and check just after the falling edge, then apply the FIFO pops it caused.
    task automatic cyc();
        bit   pop_l;
        bit   pop_r;
        exp_t e;
        #1;
        pop_l = lp_buf_rd_en;
        pop_r = rp_buf_rd_en;
        if (aresetn) begin
            if (hold_v) begin
                chk("hold_valid", m_axis_tvalid, 1);
                chk_data("hold_data", m_axis_tdata, hold_d);
                chk("hold_flags", {m_axis_tlast, m_axis_tuser}, {hold_l, hold_u});
            end
            if (pop_l) chk("lp_pop_nonempty", lp_buf_empty, 0);
            if (pop_r) chk("rp_pop_nonempty", rp_buf_empty, 0);
            if (pop_r) chk("rp_pop_slot_free", m_axis_tvalid & ~m_axis_tready, 0);
            if (m_axis_tvalid && m_axis_tready) begin
                chk("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk_data("tdata", m_axis_tdata, e.data);
                    chk("tlast", m_axis_tlast, e.last);
                    chk("tuser", m_axis_tuser, e.user);
                end
                acc_cnt++;
            end
            hold_v = m_axis_tvalid & ~m_axis_tready;
            hold_d = m_axis_tdata;
            hold_l = m_axis_tlast;
            hold_u = m_axis_tuser;
        end else begin
            hold_v = 1'b0;
        end
        @(posedge aclk);
        @(negedge aclk);
        cycn++;
        if (pop_l && lp_q.size() > 0) begin
            lp_q.delete(0);
            lp_pops++;
        end
        if (pop_r && rp_q.size() > 0) begin
            rp_q.delete(0);
            fire_cyc.push_back(cycn);
        end
        drive();
    endtask

    // A row is one sample stream; beat k sees stream samples [k*BS, k*BS+MD+BS).
    task automatic add_row(input int nbeats, input int nwords, input bit defer);
        logic [DW-1:0] s[$];
        logic [LW-1:0] w;
        logic [BW-1:0] b;
        logic [DW-1:0] v;
        exp_t          e;
        for (int i = 0; i < nwords; i++) begin
            for (int k = 0; k < MD; k++) begin
                v = (i == nwords - 1 && nbeats % NB == 0) ? '0 : DW'($urandom);
                w[k*DW +: DW] = v;
                s.push_back(v);
            end
            if (defer && i == nwords - 1) pend_word = w;
            else lp_q.push_back(w);
        end
        for (int k = 0; k < nbeats; k++) begin
            for (int q = 0; q < BS; q++) b[q*DW +: DW] = DW'($urandom);
            rp_q.push_back({k == nbeats - 1, b});
            for (int q = 0; q < MD + BS; q++) e.data[BW + q*DW +: DW] = s[k*BS + q];
            e.data[BW-1:0] = b;
            e.last = (k == nbeats - 1);
            e.user = (k == 0);
            exp_q.push_back(e);
        end
        drive();
    endtask

    task automatic run_drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            cyc();
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic run_acc(input int target, input int budget);
        int n = 0;
        while (acc_cnt < target && n < budget) begin
            cyc();
            n++;
        end
        chk("acc_timeout", acc_cnt >= target, 1);
    endtask

    task automatic reset_check();
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_tuser", m_axis_tuser, 0);
        chk_data("rst_tdata", m_axis_tdata, '0);
        chk("rst_err_len", err_len, 0);
        chk("rst_row_cnt", row_cnt, 0);
        chk("rst_rd_en", {lp_buf_rd_en, rp_buf_rd_en}, 0);
    endtask

    initial begin
        drive();
        repeat (3) cyc();
        #1;
        reset_check();
        @(negedge aclk);
        aresetn = 1'b1;

        // nominal 256-sample row
        acc_cnt = 0; lp_pops = 0;
        add_row(32, 3, 0);
        run_drain(200);
        chk("s1_row_cnt", row_cnt, 1);
        chk("s1_lp_pops", lp_pops, 3);
        chk("s1_beats", acc_cnt, 32);

        // downstream stall while beat 7 is presented
        acc_cnt = 0;
        add_row(32, 3, 0);
        run_acc(7, 200);
        m_axis_tready = 1'b0;
        saved = rp_q.size();
        repeat (5) cyc();
        chk("bp_no_rp_pop", rp_q.size(), saved);
        m_axis_tready = 1'b1;
        fire_cyc.delete();
        run_drain(200);
        chk("bp_fires", fire_cyc.size(), 24);
        if (fire_cyc.size() > 1) chk("bp_rate", fire_cyc[$] - fire_cyc[0], fire_cyc.size() - 1);
        chk("bp_row_cnt", row_cnt, 2);

        // left word missing at the first word boundary
        acc_cnt = 0; fire_cyc.delete();
        add_row(32, 3, 1);
        repeat (40) cyc();
        chk("stall_fires", fire_cyc.size(), 15);
        chk("stall_rp_left", rp_q.size(), 17);
        chk("stall_accepted", acc_cnt, 15);
        lp_q.push_back(pend_word);
        drive();
        run_drain(200);
        chk("stall_row_cnt", row_cnt, 3);

        // row ending early at beat 10
        chk("early_err_before", err_len, 0);
        add_row(10, 2, 0);
        run_drain(100);
        chk("early_err", err_len, 1);
        chk("early_row_cnt", row_cnt, 4);
        chk("early_lp_left", lp_q.size(), 0);
        repeat (5) cyc();
        chk("early_err_sticky", err_len, 1);

        // reset in the middle of a row, then a fresh row
        acc_cnt = 0;
        add_row(32, 3, 0);
        run_acc(20, 200);
        aresetn = 1'b0;
        cyc();
        #1;
        reset_check();
        lp_q.delete(); rp_q.delete(); exp_q.delete();
        @(negedge aclk);
        drive();
        aresetn = 1'b1;
        acc_cnt = 0; lp_pops = 0;
        add_row(32, 3, 0);
        run_drain(200);
        chk("rst_row_cnt_after", row_cnt, 1);
        chk("rst_lp_pops", lp_pops, 3);
        chk("rst_err_clear", err_len, 0);

        // two prefilled rows back to back
        fire_cyc.delete();
        add_row(32, 3, 0);
        add_row(32, 3, 0);
        run_drain(300);
        chk("b2b_fires", fire_cyc.size(), 64);
        if (fire_cyc.size() == 64) begin
            chk("b2b_row0_rate", fire_cyc[31] - fire_cyc[0], 31);
            chk("b2b_gap", fire_cyc[32] - fire_cyc[31], 3);
            chk("b2b_row1_rate", fire_cyc[63] - fire_cyc[32], 31);
        end
        chk("b2b_row_cnt", row_cnt, 3);

        // random downstream backpressure
        rand_rdy = 1'b1;
        add_row(32, 3, 0);
        run_drain(800);
        rand_rdy = 1'b0;
        m_axis_tready = 1'b1;
        chk("rand_row_cnt", row_cnt, 4);

        repeat (3) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
